// File: rtl/race_sequencer.sv
// race_sequencer: per-frame race phase controller for the pixel pipeline.
// Ports:
//   pclk, rst (async active-low)
//   frame_ended, lap_pulse  per-frame / per-lap pulses
//   btn_start, btn_left/right/up/down  asynchronous buttons
//   bg/track/player_visible  layer enables
//   xpos, ypos  player sprite top-left
//   countdown, lap, state  game status
module race_sequencer #(
    parameter int FRAMES_PER_STEP = 60,
    parameter int LAPS            = 3,
    parameter int STEP            = 4,
    parameter int X_START         = 480,
    parameter int Y_START         = 600,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 960,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 704
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_ended,
    input  logic        btn_start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        lap_pulse,
    output logic        bg_visible,
    output logic        track_visible,
    output logic        player_visible,
    output logic [10:0] xpos,
    output logic [10:0] ypos,
    output logic [1:0]  countdown,
    output logic [3:0]  lap,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        FINISH    = 2'd3
    } state_t;

    localparam logic [7:0]  FPS_M1  = 8'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]  LAPS_M1 = 4'(LAPS - 1);
    localparam logic [10:0] X_INIT  = 11'(X_START);
    localparam logic [10:0] Y_INIT  = 11'(Y_START);

    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
    localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
    localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

    state_t cur, nxt;
    logic [7:0] frame_cnt;
    logic       vis_nxt;

    // Buttons: {start, up, down, left, right}
    logic [4:0] sync1, sync2;
    logic       start_d;
    logic       start_edge;
    logic       s_up, s_down, s_left, s_right;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            start_d <= 1'b0;
        end else begin
            sync1   <= {btn_start, btn_up, btn_down, btn_left, btn_right};
            sync2   <= sync1;
            start_d <= sync2[4];
        end
    end

    assign start_edge = sync2[4] & ~start_d;
    assign s_up       = sync2[3];
    assign s_down     = sync2[2];
    assign s_left     = sync2[1];
    assign s_right    = sync2[0];

    logic cd_done, last_lap;
    assign cd_done  = frame_ended && (frame_cnt == FPS_M1)
                      && (countdown == 2'd1);
    assign last_lap = lap_pulse && (lap == LAPS_M1);

    // State register
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    // Next state
    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:      if (start_edge) nxt = COUNTDOWN;
            COUNTDOWN: if (cd_done)    nxt = RACE;
            RACE:      if (last_lap)   nxt = FINISH;
            FINISH:    if (start_edge) nxt = IDLE;
        endcase
    end

    // Output decode: enables follow the state they are registered with
    always_comb begin
        vis_nxt = (nxt != IDLE);
    end

    // Movement with 12-bit signed intermediates so stepping below 0 clamps
    logic signed [11:0] x_dlt, y_dlt, x_sum, y_sum, x_clp, y_clp;
    logic [10:0]        x_next, y_next;

    always_comb begin
        x_dlt = '0;
        y_dlt = '0;
        if (s_right && !s_left)      x_dlt = STEP_S;
        else if (s_left && !s_right) x_dlt = -STEP_S;
        if (s_down && !s_up)         y_dlt = STEP_S;
        else if (s_up && !s_down)    y_dlt = -STEP_S;
        x_sum = signed'({1'b0, xpos}) + x_dlt;
        y_sum = signed'({1'b0, ypos}) + y_dlt;
        x_clp = x_sum;
        y_clp = y_sum;
        if (x_sum < XMIN_S)      x_clp = XMIN_S;
        else if (x_sum > XMAX_S) x_clp = XMAX_S;
        if (y_sum < YMIN_S)      y_clp = YMIN_S;
        else if (y_sum > YMAX_S) y_clp = YMAX_S;
        x_next = x_clp[10:0];
        y_next = y_clp[10:0];
    end

    // Registered datapath and outputs
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bg_visible     <= 1'b1;
            track_visible  <= 1'b0;
            player_visible <= 1'b0;
            xpos           <= X_INIT;
            ypos           <= Y_INIT;
            countdown      <= 2'd0;
            lap            <= 4'd0;
            frame_cnt      <= 8'd0;
        end else begin
            bg_visible     <= 1'b1;
            track_visible  <= vis_nxt;
            player_visible <= vis_nxt;
            unique case (cur)
                IDLE: begin
                    xpos      <= X_INIT;
                    ypos      <= Y_INIT;
                    lap       <= 4'd0;
                    countdown <= start_edge ? 2'd3 : 2'd0;
                end
                COUNTDOWN: begin
                    if (frame_ended) begin
                        if (frame_cnt == FPS_M1) begin
                            frame_cnt <= 8'd0;
                            countdown <= countdown - 2'd1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                RACE: begin
                    if (frame_ended) begin
                        xpos <= x_next;
                        ypos <= y_next;
                    end
                    if (lap_pulse) lap <= lap + 4'd1;
                end
                FINISH: begin
                    if (start_edge) begin
                        xpos <= X_INIT;
                        ypos <= Y_INIT;
                        lap  <= 4'd0;
                    end
                end
            endcase
            if (nxt != cur) frame_cnt <= 8'd0;
        end
    end

    assign state = cur;

endmodule
